// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops async_fifo read-side entries and packs RATIO of
// them into one valid/ready word; flush emits a keep-masked partial word.
module fifo_rd_packer #(
  parameter int IN_WIDTH  = 8,
  parameter int RATIO     = 4,
  parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 rd_clk,
  input  logic                 rst_n,
  output logic                 fifo_rd_en_o,
  input  logic [IN_WIDTH-1:0]  fifo_data_i,
  input  logic                 fifo_valid_i,
  input  logic                 fifo_empty_i,
  input  logic                 flush_i,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic [RATIO-1:0]     out_keep_o,
  output logic                 out_last_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [15:0]          word_cnt_o
);
  localparam int CW = $clog2(RATIO + 1);
  localparam logic [CW-1:0] FULL = CW'(RATIO);

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    FLUSH_WAIT
  } state_t;

  state_t                         r_state;
  logic [CW-1:0]                  r_byte_cnt;
  logic                           r_inflight;
  logic                           r_flush_pend;
  logic [RATIO-1:0][IN_WIDTH-1:0] r_asm;

  logic [CW-1:0]                  w_sum;
  logic [CW-1:0]                  w_cnt_nxt;
  logic [RATIO-1:0][IN_WIDTH-1:0] w_asm;
  logic                           w_free;
  logic                           w_flush;
  logic                           w_xfer;
  logic                           w_load;
  logic                           w_load_last;
  logic [CW-1:0]                  w_load_cnt;
  logic [RATIO-1:0]               w_keep;
  logic [OUT_WIDTH-1:0]           w_word;
  state_t                         w_state_nxt;
  logic                           w_pend_nxt;

  assign w_sum     = r_byte_cnt + CW'(r_inflight);
  assign w_cnt_nxt = r_byte_cnt + CW'(fifo_valid_i);
  assign w_free    = !out_valid_o || out_ready_i;
  assign w_flush   = flush_i || r_flush_pend;
  assign w_xfer    = out_valid_o && out_ready_i;

  assign fifo_rd_en_o = rst_n && (r_state == FILL)
                      && !fifo_empty_i && !r_flush_pend
                      && (w_sum < FULL);

  // Lane view including the entry landing this cycle
  always_comb begin
    w_asm = r_asm;
    for (int i = 0; i < RATIO; i++) begin
      if (fifo_valid_i && (r_byte_cnt == CW'(i)))
        w_asm[i] = fifo_data_i;
    end
  end

  always_comb begin
    w_load      = 1'b0;
    w_load_last = 1'b0;
    w_load_cnt  = w_cnt_nxt;
    w_state_nxt = r_state;
    w_pend_nxt  = r_flush_pend;
    unique case (r_state)
      FILL: begin
        if (w_cnt_nxt == FULL) begin
          if (w_free) w_load = 1'b1;
          else        w_state_nxt = HOLD;
        end else if (w_flush && r_inflight) begin
          w_state_nxt = FLUSH_WAIT;
          w_pend_nxt  = 1'b0;
        end else if (w_flush && (w_cnt_nxt != '0)) begin
          if (w_free) begin
            w_load      = 1'b1;
            w_load_last = 1'b1;
            w_pend_nxt  = 1'b0;
          end else begin
            w_pend_nxt = 1'b1;
          end
        end else if (w_flush) begin
          w_pend_nxt = 1'b0;
        end
      end
      HOLD: begin
        w_load_cnt = FULL;
        if (out_ready_i) begin
          w_load      = 1'b1;
          w_load_last = r_flush_pend || flush_i;
          w_pend_nxt  = 1'b0;
          w_state_nxt = FILL;
        end else if (flush_i) begin
          w_pend_nxt = 1'b1;
        end
      end
      FLUSH_WAIT: begin
        if ((!r_inflight || fifo_valid_i) && w_free) begin
          w_load      = (w_cnt_nxt != '0);
          w_load_last = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_comb begin
    w_keep = '0;
    w_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      w_keep[i] = (CW'(i) < w_load_cnt);
      w_word[i*IN_WIDTH +: IN_WIDTH] =
        w_keep[i] ? w_asm[i] : '0;
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FILL;
      r_byte_cnt   <= '0;
      r_inflight   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_asm        <= '0;
      out_data_o   <= '0;
      out_keep_o   <= '0;
      out_last_o   <= 1'b0;
      out_valid_o  <= 1'b0;
      word_cnt_o   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_pend <= w_pend_nxt;
      if (fifo_rd_en_o)      r_inflight <= 1'b1;
      else if (fifo_valid_i) r_inflight <= 1'b0;
      if (w_load) begin
        r_byte_cnt  <= '0;
        r_asm       <= '0;
        out_data_o  <= w_word;
        out_keep_o  <= w_keep;
        out_last_o  <= w_load_last;
        out_valid_o <= 1'b1;
      end else begin
        r_byte_cnt <= w_cnt_nxt;
        r_asm      <= w_asm;
        if (out_ready_i) out_valid_o <= 1'b0;
      end
      if (w_xfer) word_cnt_o <= word_cnt_o + 16'd1;
    end
  end

  // Pops stop at RATIO, so no entry can land on a full assembly
  a_no_overrun: assert property (
    @(posedge rd_clk) disable iff (!rst_n)
    !(fifo_valid_i && (r_byte_cnt == FULL))
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed + random checks of fifo_rd_packer against
// a byte-queue FIFO model and a word-level packing reference.
module tb_fifo_rd_packer;
  localparam int R = 4;

  logic        rd_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_rd_en_o;
  logic [7:0]  fifo_data_i = 8'h00;
  logic        fifo_valid_i = 1'b0;
  logic        fifo_empty_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] out_data_o;
  logic [3:0]  out_keep_o;
  logic        out_last_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] word_cnt_o;

  fifo_rd_packer #(.IN_WIDTH(8), .RATIO(R)) dut (
    .rd_clk       (rd_clk),
    .rst_n        (rst_n),
    .fifo_rd_en_o (fifo_rd_en_o),
    .fifo_data_i  (fifo_data_i),
    .fifo_valid_i (fifo_valid_i),
    .fifo_empty_i (fifo_empty_i),
    .flush_i      (flush_i),
    .out_data_o   (out_data_o),
    .out_keep_o   (out_keep_o),
    .out_last_o   (out_last_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .word_cnt_o   (word_cnt_o)
  );

  always #5 rd_clk = ~rd_clk;

  int n_pass = 0;
  int n_total = 0;
  int pops = 0;
  int bad_pops = 0;
  logic        rd_s = 1'b0;
  logic        p_hold = 1'b0;
  logic [37:0] p_word = '0;
  logic [7:0]  fq[$];
  logic [7:0]  pend[$];
  logic [36:0] got[$];
  logic [36:0] exp_q[$];

  function automatic void chk(string tag, logic [63:0] obs,
                              logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endfunction

  // Reference: absorbed bytes group into words of R; flush emits the rest
  function automatic void m_emit(logic last);
    logic [31:0] d;
    logic [3:0]  k;
    d = '0;
    k = '0;
    for (int i = 0; i < pend.size(); i++) begin
      d = d | (32'(pend[i]) << (8 * i));
      k[i] = 1'b1;
    end
    exp_q.push_back({last, k, d});
    pend.delete();
  endfunction

  function automatic void m_byte(logic [7:0] b);
    pend.push_back(b);
    if (pend.size() == R) m_emit(1'b0);
  endfunction

  function automatic void m_flush();
    if (pend.size() > 0) m_emit(1'b1);
  endfunction

  // Output monitor and pop request sampled mid-cycle
  always @(negedge rd_clk) begin
    #2;
    rd_s = fifo_rd_en_o;
    if (rst_n && p_hold)
      chk("hold_stable",
          {out_valid_o, out_last_o, out_keep_o, out_data_o}, p_word);
    if (rst_n && out_valid_o && out_ready_i)
      got.push_back({out_last_o, out_keep_o, out_data_o});
    p_hold = rst_n && out_valid_o && !out_ready_i;
    p_word = {1'b1, out_last_o, out_keep_o, out_data_o};
  end

  // FIFO read side: data with valid one cycle after an accepted pop
  always @(posedge rd_clk) begin
    if (rd_s) begin
      pops++;
      if (fq.size() == 0) begin
        bad_pops++;
        fifo_valid_i <= 1'b0;
      end else begin
        fifo_data_i  <= fq.pop_front();
        fifo_valid_i <= 1'b1;
      end
    end else begin
      fifo_valid_i <= 1'b0;
    end
    fifo_empty_i <= (fq.size() == 0);
  end

  task automatic run(input int n);
    repeat (n) @(negedge rd_clk);
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    m_byte(b);
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(negedge rd_clk);
    flush_i = 1'b0;
    m_flush();
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_nwords"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(tag, 64'(got[i]), 64'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic wait_pops(input int target, input string tag);
    for (int i = 0; i < 40 && pops < target; i++)
      @(negedge rd_clk);
    chk(tag, 64'(pops), 64'(target));
  endtask

  initial begin
    int base;
    int n;
    int wexp;
    logic [15:0] c0;

    run(3);
    chk("rst_outs", {fifo_rd_en_o, out_valid_o, out_last_o,
                     out_keep_o, out_data_o, word_cnt_o}, 64'd0);
    rst_n = 1'b1;
    run(2);

    // Two full words, no back-pressure
    out_ready_i = 1'b1;
    base = pops;
    for (int i = 0; i < 8; i++) push(8'(i));
    run(20);
    chk("t1_pops", 64'(pops - base), 64'd8);
    chk("t1_wcnt", 64'(word_cnt_o), 64'd2);
    chk("t1_w0", 64'(got[0]), {27'd0, 1'b0, 4'hF, 32'h03020100});
    chk("t1_w1", 64'(got[1]), {27'd0, 1'b0, 4'hF, 32'h07060504});
    check_stream("t1");

    // Back-pressure: first word held, second parked in HOLD
    out_ready_i = 1'b0;
    base = pops;
    c0 = word_cnt_o;
    for (int i = 0; i < 8; i++) push(8'(i));
    run(20);
    chk("t2_valid", 64'(out_valid_o), 64'd1);
    chk("t2_held", 64'(out_data_o), 64'h03020100);
    chk("t2_pops", 64'(pops - base), 64'd8);
    out_ready_i = 1'b1;
    run(10);
    chk("t2_wcnt", 64'(16'(word_cnt_o - c0)), 64'd2);
    check_stream("t2");

    // Partial flush, then an empty flush
    push(8'h0A);
    push(8'h0B);
    push(8'h0C);
    run(10);
    do_flush();
    run(5);
    chk("t3_part", 64'(got[0]), {27'd0, 1'b1, 4'b0111, 32'h000C0B0A});
    check_stream("t3");
    c0 = word_cnt_o;
    do_flush();
    run(5);
    chk("t3_noflush_cnt", 64'(word_cnt_o), 64'(c0));
    chk("t3_noflush_data", 64'(out_data_o), 64'h000C0B0A);
    check_stream("t3e");

    // Flush with an entry in flight
    base = pops;
    push(8'h21);
    push(8'h22);
    wait_pops(base + 2, "t4_pop2");
    do_flush();
    run(6);
    chk("t4_nopop", 64'(pops), 64'(base + 2));
    chk("t4_word", 64'(got[0]), {27'd0, 1'b1, 4'b0011, 32'h00002221});
    check_stream("t4");

    // Empty FIFO: no pops, no words
    base = pops;
    run(20);
    chk("t5_pops", 64'(pops), 64'(base));
    chk("t5_valid", 64'(out_valid_o), 64'd0);

    // Reset mid-word discards the partial lanes
    base = pops;
    push(8'hEE);
    push(8'hEF);
    wait_pops(base + 2, "t6_pop2");
    run(2);
    rst_n = 1'b0;
    #1;
    chk("t6_async", {fifo_rd_en_o, out_valid_o, out_last_o,
                     out_keep_o, out_data_o, word_cnt_o}, 64'd0);
    pend.delete();
    run(3);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    run(15);
    chk("t6_word", 64'(got[0]), {27'd0, 1'b0, 4'hF, 32'h13121110});
    chk("t6_wcnt", 64'(word_cnt_o), 64'd1);
    check_stream("t6");

    // Random byte streams with random back-pressure, then flush
    for (int it = 0; it < 8; it++) begin
      c0 = word_cnt_o;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) push(8'($urandom));
      for (int i = 0; i < 600 && fq.size() > 0; i++) begin
        @(negedge rd_clk);
        out_ready_i = 1'($urandom_range(0, 1));
      end
      chk("rnd_drain", 64'(fq.size()), 64'd0);
      out_ready_i = 1'b1;
      run(12);
      do_flush();
      run(8);
      wexp = exp_q.size();
      chk("rnd_wcnt", 64'(16'(word_cnt_o - c0)), 64'(wexp));
      check_stream("rnd");
    end

    chk("no_empty_pop", 64'(bad_pops), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
